// File: rtl/adma_pkg.sv
// Shared definitions for the ADMA2 data mover: FSM state encoding,
// transfer direction codes, maximum descriptor length and the byte-enable
// helper used for the final partial word of a transfer.
package adma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_H2C_REQ,
    S_H2C_PUSH,
    S_C2H_POP,
    S_C2H_LAT,
    S_C2H_REQ,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic DIR_H2C = 1'b0;
  localparam logic DIR_C2H = 1'b1;

  localparam int ADMA_MAX_LEN = 65536;
  localparam int REM_W        = 17;

  // Lanes valid in the current word given the bytes still to move.
  function automatic logic [3:0] be_from_rem(input logic [REM_W-1:0] rem);
    if (rem >= REM_W'(4)) return 4'b1111;
    case (rem[1:0])
      2'd3:    return 4'b0111;
      2'd2:    return 4'b0011;
      2'd1:    return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/adma_byte_counter.sv
// Transfer bookkeeping for the data mover: remaining bytes, bytes done and
// the current word address.
//   load        : latch address and length (0 = 65536), clear byte count
//   step        : one word moved; consume min(rem,4) bytes, advance 4
//   cur_adr     : address of the word to move next
//   xfer_bytes  : bytes completed so far
//   be_cur      : byte lanes valid in the current word
//   last        : current word is the final one
module adma_byte_counter
  import adma_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] ld_adr,
  input  logic [15:0]       ld_len,
  output logic [ADDR_W-1:0] cur_adr,
  output logic [REM_W-1:0]  xfer_bytes,
  output logic [3:0]        be_cur,
  output logic              last
);

  logic [REM_W-1:0] rem;
  logic [REM_W-1:0] amt;

  assign amt    = (rem >= REM_W'(4)) ? REM_W'(4) : rem;
  assign be_cur = be_from_rem(rem);
  assign last   = (rem <= REM_W'(4));

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_adr    <= '0;
      rem        <= '0;
      xfer_bytes <= '0;
    end else if (load) begin
      cur_adr    <= ld_adr;
      rem        <= (ld_len == 16'd0) ? REM_W'(ADMA_MAX_LEN) : {1'b0, ld_len};
      xfer_bytes <= '0;
    end else if (step) begin
      cur_adr    <= cur_adr + ADDR_W'(4);   // wraps modulo 2^ADDR_W
      rem        <= rem - amt;
      xfer_bytes <= xfer_bytes + amt;
    end
  end

endmodule

// File: rtl/adma_data_mover.sv
// ADMA2 transfer engine. While the descriptor FSM holds start, moves
// dat_len bytes between system memory and the SD TX/RX FIFOs one 32-bit
// word at a time, then holds done until start drops.
//   start/dir/dat_len/dat_adr : descriptor and permission from ADMA FSM
//   mem_*                     : word-addressed memory port, req held to ack
//   txf_*                     : TX FIFO push side (host-to-card)
//   rxf_*                     : RX FIFO pop side, data one cycle after rd
//   busy/done/adr_err         : status back to the ADMA FSM
//   xfer_bytes                : bytes completed in the current transfer
module adma_data_mover
  import adma_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                dir,
  input  logic [15:0]         dat_len,
  input  logic [ADDR_W-1:0]   dat_adr,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                txf_wr,
  output logic [DATA_W-1:0]   txf_data,
  output logic [DATA_W/8-1:0] txf_be,
  input  logic                txf_full,
  output logic                rxf_rd,
  input  logic [DATA_W-1:0]   rxf_data,
  input  logic                rxf_empty,
  output logic                busy,
  output logic                done,
  output logic                adr_err,
  output logic [REM_W-1:0]    xfer_bytes
);

  state_t              state;
  logic                cnt_load;
  logic                cnt_step;
  logic [ADDR_W-1:0]   cur_adr;
  logic [3:0]          be_cur;
  logic                last;

  assign cnt_load = (state == S_IDLE) && start;
  assign cnt_step = (state == S_H2C_PUSH) ||
                    ((state == S_C2H_REQ) && mem_req && mem_ack);

  assign busy = !(state inside {S_IDLE, S_DONE, S_ERR});

  adma_byte_counter #(.ADDR_W(ADDR_W)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .step       (cnt_step),
    .ld_adr     (dat_adr),
    .ld_len     (dat_len),
    .cur_adr    (cur_adr),
    .xfer_bytes (xfer_bytes),
    .be_cur     (be_cur),
    .last       (last)
  );

  // txf_data / mem_wdata double as the captured data word: each is loaded
  // on the same edge the word is received, so no separate holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      txf_wr    <= 1'b0;
      txf_data  <= '0;
      txf_be    <= '0;
      rxf_rd    <= 1'b0;
      done      <= 1'b0;
      adr_err   <= 1'b0;
    end else begin
      txf_wr <= 1'b0;
      case (state)
        S_IDLE: begin
          done    <= 1'b0;
          adr_err <= 1'b0;
          if (start) begin
            if (dat_adr[1:0] != 2'b00) begin
              state   <= S_ERR;
              adr_err <= 1'b1;
              done    <= 1'b1;
            end else if (dir == DIR_H2C) begin
              state <= S_H2C_REQ;
              // issue the first read straight away when the FIFO has room
              if (!txf_full) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= dat_adr;
                mem_be   <= '1;
              end
            end else begin
              state  <= S_C2H_POP;
              rxf_rd <= !rxf_empty;
            end
          end
        end

        S_H2C_REQ: begin
          if (mem_req) begin
            if (mem_ack) begin
              mem_req <= 1'b0;
              if (start) begin
                state    <= S_H2C_PUSH;
                txf_wr   <= 1'b1;
                txf_data <= mem_rdata;
                txf_be   <= be_cur;
              end else begin
                state <= S_IDLE;   // aborted: in-flight read retired
              end
            end
          end else if (!start) begin
            state <= S_IDLE;
          end else if (!txf_full) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= cur_adr;
            mem_be   <= '1;
          end
        end

        S_H2C_PUSH: begin
          if (!start)    state <= S_IDLE;
          else if (last) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else       state <= S_H2C_REQ;
        end

        S_C2H_POP: begin
          // rxf_rd high here means a word is already leaving the FIFO and
          // must be written even if start has dropped.
          if (rxf_rd) begin
            rxf_rd <= 1'b0;
            state  <= S_C2H_LAT;
          end else if (!start) begin
            state <= S_IDLE;
          end else if (!rxf_empty) begin
            rxf_rd <= 1'b1;
          end
        end

        S_C2H_LAT: begin
          state     <= S_C2H_REQ;
          mem_req   <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= cur_adr;
          mem_be    <= be_cur;
          mem_wdata <= rxf_data;
        end

        S_C2H_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!start) state <= S_IDLE;
            else if (last) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              // pop the next word on this edge to keep 3 cycles per word
              state  <= S_C2H_POP;
              rxf_rd <= !rxf_empty;
            end
          end
        end

        S_DONE: begin
          if (!start) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end

        S_ERR: begin
          if (!start) begin
            state   <= S_IDLE;
            done    <= 1'b0;
            adr_err <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adma_data_mover.sv
// Directed bench for adma_data_mover: zero-wait memory/FIFO models with an
// adjustable ack delay, a negedge monitor logging accesses and pushes, and
// hand-computed expectations checked with immediate assertions.
module tb_adma_data_mover;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic [15:0] dat_len = '0;
  logic [63:0] dat_adr = '0;
  logic        mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        txf_wr, txf_full = 1'b0;
  logic [31:0] txf_data;
  logic [3:0]  txf_be;
  logic        rxf_rd, rxf_empty = 1'b0;
  logic [31:0] rxf_data = '0;
  logic        busy, done, adr_err;
  logic [16:0] xfer_bytes;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  adma_data_mover dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .dat_len(dat_len),
    .dat_adr(dat_adr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .txf_wr(txf_wr), .txf_data(txf_data), .txf_be(txf_be),
    .txf_full(txf_full), .rxf_rd(rxf_rd), .rxf_data(rxf_data),
    .rxf_empty(rxf_empty), .busy(busy), .done(done), .adr_err(adr_err),
    .xfer_bytes(xfer_bytes)
  );

  // memory: read data derived from address, ack after ack_delay wait cycles
  int ack_delay = 0;
  int wait_cnt = 0;
  logic clr_log = 1'b0;
  assign mem_rdata = mem_addr[31:0] ^ 32'hC0DE_0000;
  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  // RX FIFO: pattern words, data one cycle after the pop
  int rx_idx = 0;
  always @(posedge clk) begin
    if (clr_log) rx_idx <= 0;
    else if (rxf_rd) begin
      rxf_data <= 32'hBEEF_0000 + rx_idx;
      rx_idx   <= rx_idx + 1;
    end
  end

  // monitor
  int          n_acc = 0, n_push = 0, stab_err = 0, drop_err = 0;
  logic        done_seen = 1'b0, prev_pend = 1'b0;
  logic [100:0] prev_vec = '0;
  logic [63:0] acc_addr [8];
  logic [3:0]  acc_be   [8];
  logic        acc_we   [8];
  logic [31:0] acc_wd   [8];
  logic [31:0] push_d   [8];
  logic [3:0]  push_be  [8];
  logic [63:0] last_addr = '0;

  always @(negedge clk) begin
    if (clr_log) begin
      n_acc <= 0; n_push <= 0; stab_err <= 0; drop_err <= 0;
      done_seen <= 1'b0; prev_pend <= 1'b0;
    end else begin
      if (mem_req && mem_ack) begin
        if (n_acc < 8) begin
          acc_addr[n_acc[2:0]] <= mem_addr;
          acc_be[n_acc[2:0]]   <= mem_be;
          acc_we[n_acc[2:0]]   <= mem_we;
          acc_wd[n_acc[2:0]]   <= mem_wdata;
        end
        last_addr <= mem_addr;
        n_acc     <= n_acc + 1;
      end
      if (txf_wr) begin
        if (n_push < 8) begin
          push_d[n_push[2:0]]  <= txf_data;
          push_be[n_push[2:0]] <= txf_be;
        end
        n_push <= n_push + 1;
      end
      if (prev_pend && !mem_req) drop_err <= drop_err + 1;
      if (prev_pend && mem_req && ({mem_addr, mem_we, mem_be, mem_wdata} !== prev_vec))
        stab_err <= stab_err + 1;
      prev_pend <= mem_req && !mem_ack;
      prev_vec  <= {mem_addr, mem_we, mem_be, mem_wdata};
      if (done) done_seen <= 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    clr_log = 1'b1;
    step(1);
    clr_log = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int cyc);
    cyc = 0;
    while (!done && cyc < bound) begin
      step(1);
      cyc++;
    end
    chk("done_reached", done, 1);
  endtask

  int cyc;
  int guard;

  initial begin
    // reset state
    step(3);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_txf_wr", txf_wr, 0);
    chk("rst_rxf_rd", rxf_rd, 0);
    chk("rst_status", {busy, done, adr_err}, 0);
    chk("rst_xfer", xfer_bytes, 0);
    reset = 1'b0;
    step(1);

    // H2C 16 bytes @0x1000, zero-wait
    clear_log();
    dir = 1'b0; dat_len = 16'd16; dat_adr = 64'h1000; start = 1'b1;
    wait_done(40, cyc);
    chk("h2c_cycles", cyc, 12);
    chk("h2c_nacc", n_acc, 4);
    chk("h2c_adr0", acc_addr[0], 64'h1000);
    chk("h2c_adr1", acc_addr[1], 64'h1004);
    chk("h2c_adr2", acc_addr[2], 64'h1008);
    chk("h2c_adr3", acc_addr[3], 64'h100C);
    chk("h2c_we", {acc_we[0], acc_we[3]}, 0);
    chk("h2c_npush", n_push, 4);
    chk("h2c_push0", push_d[0], 32'hC0DE_1000);
    chk("h2c_push3", push_d[3], 32'hC0DE_100C);
    chk("h2c_pushbe", {push_be[0], push_be[3]}, 8'hFF);
    chk("h2c_xfer", xfer_bytes, 16);
    chk("h2c_busy", busy, 0);
    start = 1'b0;
    step(1);
    chk("h2c_done_fall", done, 0);

    // C2H 6 bytes @0x2000
    clear_log();
    dir = 1'b1; dat_len = 16'd6; dat_adr = 64'h2000; start = 1'b1;
    wait_done(40, cyc);
    chk("c2h_cycles", cyc, 7);
    chk("c2h_nacc", n_acc, 2);
    chk("c2h_adr0", acc_addr[0], 64'h2000);
    chk("c2h_adr1", acc_addr[1], 64'h2004);
    chk("c2h_be0", acc_be[0], 4'hF);
    chk("c2h_be1", acc_be[1], 4'h3);
    chk("c2h_we", {acc_we[0], acc_we[1]}, 2'b11);
    chk("c2h_wd0", acc_wd[0], 32'hBEEF_0000);
    chk("c2h_wd1", acc_wd[1], 32'hBEEF_0001);
    chk("c2h_xfer", xfer_bytes, 6);
    start = 1'b0;
    step(1);

    // misaligned descriptor address
    clear_log();
    dir = 1'b0; dat_len = 16'd8; dat_adr = 64'h1002; start = 1'b1;
    step(3);
    chk("err_flags", {adr_err, done}, 2'b11);
    chk("err_no_req", {mem_req, 28'(n_acc)}, 0);
    chk("err_busy", busy, 0);
    start = 1'b0;
    step(1);
    chk("err_clear", {adr_err, done}, 0);

    // FIFO full stall + slow memory, 11 bytes (last word 3 lanes)
    clear_log();
    ack_delay = 3;
    dir = 1'b0; dat_len = 16'd11; dat_adr = 64'h3000; start = 1'b1;
    guard = 0;
    while (n_push < 1 && guard < 40) begin step(1); guard++; end
    chk("stall_first_push", n_push, 1);
    txf_full = 1'b1;
    step(5);
    txf_full = 1'b0;
    wait_done(80, cyc);
    chk("stall_nacc", n_acc, 3);
    chk("stall_npush", n_push, 3);
    chk("stall_push2", push_d[2], 32'hC0DE_3008);
    chk("stall_be", {push_be[1], push_be[2]}, 8'hF7);
    chk("stall_drop", drop_err, 0);
    chk("stall_stable", stab_err, 0);
    chk("stall_xfer", xfer_bytes, 11);
    start = 1'b0;
    ack_delay = 0;
    step(1);

    // 65536-byte transfer across the top of the address space
    clear_log();
    dir = 1'b0; dat_len = 16'd0; dat_adr = 64'hFFFF_FFFF_FFFF_FFF0; start = 1'b1;
    wait_done(60000, cyc);
    chk("max_nacc", n_acc, 16384);
    chk("max_npush", n_push, 16384);
    chk("max_adr3", acc_addr[3], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("max_adr4", acc_addr[4], 64'h0);
    chk("max_last", last_addr, 64'h0000_0000_0000_FFEC);
    chk("max_xfer", xfer_bytes, 17'h10000);
    start = 1'b0;
    step(1);

    // abort with a read in flight
    clear_log();
    ack_delay = 3;
    dir = 1'b0; dat_len = 16'd16; dat_adr = 64'h4000; start = 1'b1;
    step(2);
    chk("abort_req_pending", mem_req, 1);
    start = 1'b0;
    guard = 0;
    while (busy && guard < 20) begin step(1); guard++; end
    step(1);
    chk("abort_idle", {busy, mem_req}, 0);
    chk("abort_nacc", n_acc, 1);
    chk("abort_npush", n_push, 0);
    chk("abort_no_done", done_seen, 0);
    chk("abort_drop", drop_err, 0);
    ack_delay = 0;

    // reset in the middle of a C2H transfer
    clear_log();
    dir = 1'b1; dat_len = 16'd16; dat_adr = 64'h5000; start = 1'b1;
    step(6);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    step(1);
    chk("rstmid_strobes", {mem_req, rxf_rd, txf_wr, mem_we}, 0);
    chk("rstmid_status", {busy, done, adr_err}, 0);
    chk("rstmid_xfer", xfer_bytes, 0);
    chk("rstmid_addr", mem_addr, 0);
    chk("rstmid_wdata", {mem_wdata, mem_be}, 0);
    reset = 1'b0;
    start = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
